mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Pipeline-side initiator for the byte-addressed, little-endian 64-bit data memory.
//  Turns load/store requests of size B/H/W/D into memory bus cycles.
//  Loads are sign- or zero-extended. Sub-doubleword stores use read-modify-write.
//  Sits between the MEM stage and the data memory, which owns one shared inout data bus.
// PARAMETERS
//  MEM_SIZE  9192  bytes of backing memory; an access is legal iff addr <= MEM_SIZE-8
//  AW        64    address width
// PORTS
//  clk          in   1   single clock, all state updates on posedge
//  rst_n        in   1   synchronous active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   unit idle, request accepted when valid&ready
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   00=B 01=H 10=W 11=D
//  req_unsigned in   1   loads: 1=zero-extend, 0=sign-extend
//  req_addr     in   AW  byte address
//  req_wdata    in   64  store data, right-justified
//  resp_valid   out  1   response present, held until resp_ready
//  resp_ready   in   1   consumer accepts response
//  resp_rdata   out  64  extended load data (0 for stores)
//  resp_err     out  1   range (or alignment) fault; memory untouched
//  mem_rw       out  1   1=unit drives bus, memory writes 8 bytes on negedge
//  mem_addr     out  AW  byte address to memory
//  mem_data     inout 64 driven = wbuf when mem_rw=1, else 'z (memory drives)
// BEHAVIOUR
//  - Reset: state=IDLE. mem_rw=0. mem_addr=0. resp_valid=0. resp_rdata=0. resp_err=0. Bus released.
//  - mem_rw and mem_addr are registered. Never drive mem_data unless mem_rw=1, so there is no contention.
//  - IDLE: req_ready=1. On accept, latch all req_* fields.
//      Fault (addr > MEM_SIZE-8) -> RESP with err=1.
//      Load, or store with size != D -> RD.
//      Store with size D -> WR, with wbuf=wdata.
//  - RD: mem_rw=0, mem_addr=addr_q. At posedge, sample mem_data into rbuf.
//      Load -> RESP. resp_rdata = extend(rbuf[8*N-1:0]), where N=1/2/4/8.
//      Store -> WR. wbuf = {rbuf[63:8N], wdata[8N-1:0]}.
//  - WR: mem_rw=1, bus=wbuf. Memory commits on the falling edge. Next posedge -> RESP, with mem_rw=0.
//  - RESP: resp_valid=1. Fields are stable until resp_ready. On resp_valid&resp_ready -> IDLE.
//      req_ready=0 here, so there is no same-cycle accept.
//  - Latency from accept edge to resp_valid:
//      load: 2 edges
//      store D: 2 edges
//      store B/H/W: 3 edges
//      fault: 1 edge
//  - req_valid while busy: ignored, and the requester holds it.
//  - Address wrap is impossible: the range check precedes any bus cycle.
//  - rst_n low mid-operation: next posedge forces IDLE and mem_rw=0.
//      A write already committed on a prior negedge stands. A partial RMW (RD done, WR not) leaves memory unchanged.
// CONFIGURATION
//  MAU_ALIGN_CHECK_EN
//    defined: addr not a multiple of the access size (H:2, W:4, D:8) -> RESP, err=1, no bus cycle.
//    undefined: misaligned accesses are legal, because the memory is byte-granular.
// STRUCTURE
//  mau_pkg: size encodings (SZ_B/H/W/D), state enum (IDLE, RD, WR, RESP), size->byte-count function.
//  Sub-module mem_access_align (combinational): load extract/extend and store merge.
//    Inputs: size, unsigned, rbuf, wdata. Outputs: ext_data, merged.
//  The top level holds the FSM, request latch, bus tristate and range/alignment checks.
// TESTING
//  1. Reset, then idle -> req_ready=1, mem_rw=0, mem_data='z, resp_valid=0.
//  2. Store D 64'h0C3C3EAAF00FCC33 @0x10, then load D @0x10 -> rdata=64'h0C3C3EAAF00FCC33.
//     Store responds 2 edges after accept, with no RD cycle.
//  3. After test 2, store B 8'h5A @0x12 (RD+WR), then load D @0x10 -> 64'h0C3C3EAAF05ACC33.
//     Bytes 0x11 and 0x13..0x17 are unchanged.
//  4. With mem @0x10 = ..CC33: load H signed @0x10 -> 64'hFFFFFFFFFFFFCC33.
//     Load H unsigned @0x10 -> 64'h000000000000CC33.
//  5. Load D @MEM_SIZE-7 -> err=1 one edge after accept, mem_rw never asserted.
//     Load D @MEM_SIZE-8 -> ok.
//  6. Hold resp_ready=0 for 3 cycles -> resp fields stable, req_ready=0.
//     rst_n=0 during WR -> IDLE next edge, mem_rw=0.
//     With MAU_ALIGN_CHECK_EN: load W @0x12 -> err=1.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states
// and size helpers.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    return 3'(size_bytes(sz) - 4'd1);
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational byte lane logic: load extract/extend from the bus word and
// store merge of right-justified data into the old doubleword.
module mem_access_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [63:0] rbuf,
  input  logic [63:0] wdata,
  output logic [63:0] ext_data,
  output logic [63:0] merged
);

  always_comb begin
    ext_data = rbuf;
    merged   = wdata;
    case (size)
      SZ_B: begin
        ext_data = {{56{~uns & rbuf[7]}}, rbuf[7:0]};
        merged   = {rbuf[63:8], wdata[7:0]};
      end
      SZ_H: begin
        ext_data = {{48{~uns & rbuf[15]}}, rbuf[15:0]};
        merged   = {rbuf[63:16], wdata[15:0]};
      end
      SZ_W: begin
        ext_data = {{32{~uns & rbuf[31]}}, rbuf[31:0]};
        merged   = {rbuf[63:32], wdata[31:0]};
      end
      default: begin
        ext_data = rbuf;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the shared-bus 64-bit data memory.
// Optional: define MAU_ALIGN_CHECK_EN to fault naturally misaligned accesses.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_SIZE = 9192,
  parameter int AW       = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [63:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [63:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  inout  wire  [63:0]   mem_data
);

  localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_SIZE - 8);

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;
  logic [63:0] wbuf;
  logic [63:0] ext_data;
  logic [63:0] merged;
  logic        range_err;
  logic        misalign;
  logic        fault;

  // The bus word is consumed directly in RD so the result is registered on
  // the same edge that samples it.
  mem_access_align u_align (
    .size     (size_q),
    .uns      (uns_q),
    .rbuf     (mem_data),
    .wdata    (wdata_q),
    .ext_data (ext_data),
    .merged   (merged)
  );

  assign mem_data  = mem_rw ? wbuf : 64'bz;
  assign req_ready = (state == IDLE);

  assign range_err = (req_addr > ADDR_MAX);
`ifdef MAU_ALIGN_CHECK_EN
  assign misalign  = |(req_addr[2:0] & size_mask(req_size));
`else
  assign misalign  = 1'b0;
`endif
  assign fault     = range_err | misalign;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_B;
      wdata_q    <= '0;
      wbuf       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            size_q     <= req_size;
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (fault) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_we && req_size == SZ_D) begin
              wbuf     <= req_wdata;
              mem_addr <= req_addr;
              mem_rw   <= 1'b1;
              state    <= WR;
            end else begin
              mem_addr <= req_addr;
              state    <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            wbuf   <= merged;
            mem_rw <= 1'b1;
            state  <= WR;
          end else begin
            resp_rdata <= ext_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          // Memory committed on the preceding negedge.
          mem_rw     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-array memory model on the
// shared bus; expectations depend on whether MAU_ALIGN_CHECK_EN is defined.
module tb_mem_access_unit;

  localparam int MEM_SIZE = 9192;
  localparam int AW       = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [63:0]   resp_rdata;
  logic          resp_err;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  wire  [63:0]   mem_data;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_SIZE(MEM_SIZE), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data)
  );

  // Memory model: drives the bus when the unit does not, writes on negedge.
  logic [7:0]  mem [MEM_SIZE];
  logic [63:0] rd_word;
  logic        fill_mem = 1'b1;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 8; k++)
      if (mem_addr + 64'(k) < 64'(MEM_SIZE))
        rd_word[8*k +: 8] = mem[mem_addr + 64'(k)];
  end

  assign mem_data = mem_rw ? 64'bz : rd_word;

  always @(negedge clk) begin
    if (fill_mem) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 8'(i * 13 + 5);
    end else if (mem_rw && mem_addr <= 64'(MEM_SIZE - 8)) begin
      for (int k = 0; k < 8; k++) mem[mem_addr + 64'(k)] <= mem_data[8*k +: 8];
    end
  end

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its response and score it.
  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    logic rw_seen;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; resp_ready = (hold == 0);
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    rw_seen = mem_rw;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      rw_seen |= mem_rw;
    end
    e = sb_q.pop_front();
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".rdata"}, resp_rdata, e.rdata);
    check({tag, ".err"}, 64'(resp_err), 64'(e.err));
    check({tag, ".bus_cycle"}, 64'(rw_seen), 64'(we && !exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
      check({tag, ".hold_rdata"}, resp_rdata, e.rdata);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".released"}, 64'(resp_valid), 64'd0);
  endtask

  logic [63:0] exp_w;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    fill_mem = 1'b0;
    @(negedge clk);
    // Reset state; bus must carry the memory word untouched by the unit.
    check("rst.req_ready", 64'(req_ready), 64'd1);
    check("rst.mem_rw", 64'(mem_rw), 64'd0);
    check("rst.mem_addr", mem_addr, 64'd0);
    check("rst.resp_valid", 64'(resp_valid), 64'd0);
    check("rst.resp_rdata", resp_rdata, 64'd0);
    check("rst.resp_err", 64'(resp_err), 64'd0);
    exp_w = '0;
    for (int k = 0; k < 8; k++) exp_w[8*k +: 8] = 8'(k * 13 + 5);
    check("rst.bus", mem_data, exp_w);
    rst_n = 1'b1;

    issue("st_d",   1, 2'b11, 0, 64'h10, 64'h0C3C3EAAF00FCC33, 64'd0, 0, 2, 0);
    issue("ld_d",   0, 2'b11, 0, 64'h10, 64'd0, 64'h0C3C3EAAF00FCC33, 0, 2, 0);
    issue("st_b",   1, 2'b00, 0, 64'h12, 64'hFFFF_FFFF_FFFF_FF5A, 64'd0, 0, 3, 0);
    issue("ld_d2",  0, 2'b11, 0, 64'h10, 64'd0, 64'h0C3C3EAAF05ACC33, 0, 2, 0);
    issue("ld_hs",  0, 2'b01, 0, 64'h10, 64'd0, 64'hFFFFFFFFFFFFCC33, 0, 2, 0);
    issue("ld_hu",  0, 2'b01, 1, 64'h10, 64'd0, 64'h000000000000CC33, 0, 2, 0);
    issue("ld_bs",  0, 2'b00, 0, 64'h11, 64'd0, 64'hFFFFFFFFFFFFFFCC, 0, 2, 0);
    issue("ld_wu",  0, 2'b10, 1, 64'h14, 64'd0, 64'h000000000C3C3EAA, 0, 2, 0);
    issue("st_h",   1, 2'b01, 0, 64'h16, 64'h1234_5678_9ABC_BEEF, 64'd0, 0, 3, 0);
    issue("ld_d3",  0, 2'b11, 0, 64'h10, 64'd0, 64'hBEEF3EAAF05ACC33, 0, 2, 0);

    issue("ld_oor", 0, 2'b11, 0, 64'(MEM_SIZE - 7), 64'd0, 64'd0, 1, 1, 0);
    issue("st_top", 1, 2'b11, 0, 64'(MEM_SIZE - 8), 64'h1122334455667788, 64'd0, 0, 2, 0);
    issue("st_oor", 1, 2'b10, 0, 64'(MEM_SIZE - 7), 64'hAAAA_AAAA, 64'd0, 1, 1, 0);
    issue("ld_top", 0, 2'b11, 0, 64'(MEM_SIZE - 8), 64'd0, 64'h1122334455667788, 0, 2, 0);
    issue("ld_far", 0, 2'b00, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1, 1, 0);

    issue("hold",   0, 2'b11, 0, 64'h10, 64'd0, 64'hBEEF3EAAF05ACC33, 0, 2, 3);

`ifdef MAU_ALIGN_CHECK_EN
    issue("ld_wmis", 0, 2'b10, 0, 64'h12, 64'd0, 64'd0, 1, 1, 0);
`else
    issue("ld_wmis", 0, 2'b10, 0, 64'h12, 64'd0, 64'h000000003EAAF05A, 0, 2, 0);
`endif

    // Reset during WR: the negedge commit stands.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = 64'h20;
    req_wdata = 64'hDEADBEEF01234567;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstwr.in_wr", 64'(mem_rw), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstwr.mem_rw", 64'(mem_rw), 64'd0);
    check("rstwr.req_ready", 64'(req_ready), 64'd1);
    check("rstwr.resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    issue("rstwr.ld", 0, 2'b11, 0, 64'h20, 64'd0, 64'hDEADBEEF01234567, 0, 2, 0);

    // Reset during RD of a byte store: memory must be left unchanged.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 64'h20;
    req_wdata = 64'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstrd.mem_rw", 64'(mem_rw), 64'd0);
    check("rstrd.req_ready", 64'(req_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue("rstrd.ld", 0, 2'b11, 0, 64'h20, 64'd0, 64'hDEADBEEF01234567, 0, 2, 0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
